cpu_core_p: RTL and testbench

//  Parametrised multi-cycle accumulator-less CPU core; successor of the 16-bit/6-bit fixed core.

---
 rtl/cpu_pkg.sv | 44 ++++
 rtl/cpu_alu_p.sv | 26 ++
 rtl/register.sv | 21 ++
 rtl/cpu_core_p.sv | 228 ++++++++++++++++++++++
 tb/tb_cpu_core_p.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the parametrised multi-cycle core.
//   - opcode encodings (instruction bits [15:12])
//   - instruction field bit positions
//   - FSM state encoding and operand-index encoding
package cpu_pkg;

  localparam logic [3:0] OC_MOV  = 4'h0;
  localparam logic [3:0] OC_ADD  = 4'h1;
  localparam logic [3:0] OC_SUB  = 4'h2;
  localparam logic [3:0] OC_MUL  = 4'h3;
  localparam logic [3:0] OC_DIV  = 4'h4;
  localparam logic [3:0] OC_IN   = 4'h7;
  localparam logic [3:0] OC_OUT  = 4'h8;
  localparam logic [3:0] OC_STOP = 4'hF;

  localparam int F_OC_HI = 15;
  localparam int F_OC_LO = 12;
  localparam int F_IX    = 11;
  localparam int F_X_HI  = 10;
  localparam int F_X_LO  = 8;
  localparam int F_IY    = 7;
  localparam int F_Y_HI  = 6;
  localparam int F_Y_LO  = 4;
  localparam int F_IZ    = 3;
  localparam int F_Z_HI  = 2;
  localparam int F_Z_LO  = 0;

  typedef enum logic [3:0] {
    S_FETCH_A, S_FETCH_W, S_FETCH_L, S_DECODE,
    S_RD_A, S_RD_W, S_RD_L, S_EXEC,
    S_WB_A, S_WB_W, S_IN_WAIT, S_OUT_WAIT,
    S_HALT, S_ERROR
  } state_t;

  // Which operand the shared read micro-sequence is fetching.
  typedef enum logic [1:0] {
    OPI_Y, OPI_Z, OPI_DST, OPI_X
  } opi_t;

  function automatic logic is_binop(input logic [3:0] oc);
    return (oc == OC_ADD) || (oc == OC_SUB) || (oc == OC_MUL) || (oc == OC_DIV);
  endfunction

endpackage

// File: rtl/cpu_alu_p.sv
// cpu_alu_p: combinational ALU for the core.
//   op : opcode (MOV passes a; ADD/SUB/MUL/DIV combine a and b)
//   a,b: operands (y, z); y : result, truncated to DW bits
// Division is unsigned; a zero divisor yields all-ones.
module cpu_alu_p import cpu_pkg::*; #(
  parameter int DW = 16
) (
  input  logic [3:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] y
);

  always_comb begin
    y = a;
    case (op)
      OC_MOV: y = a;
      OC_ADD: y = a + b;
      OC_SUB: y = a - b;
      OC_MUL: y = a * b;
      OC_DIV: y = (b == '0) ? '1 : a / b;
      default: y = a;
    endcase
  end

endmodule

// File: rtl/register.sv
// register: generic enabled register with asynchronous active-low reset.
//   clk, rst_n : clock / async reset (q <= RST)
//   en, d      : load enable and data
//   q          : stored value
module register #(
  parameter int W = 8,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= RST;
    else if (en) q <= d;
  end

endmodule

// File: rtl/cpu_core_p.sv
// cpu_core_p: multi-cycle 3-operand core over one synchronous RAM.
//   clk, rst_n          : clock, async active-low reset
//   mem_addr/wdata/we   : RAM port (addr = MAR, wdata = MDR), mem_rdata 1 cycle later
//   in_data/valid/ready : input channel, transfer when in_valid && in_ready
//   out_data/valid/ready: output channel, transfer when out_valid && out_ready
//   pc, sp              : program counter, stack pointer (constant)
//   halted, error       : stopped (STOP or illegal opcode), illegal opcode seen
// Handshakes: a word moves on a cycle where valid and ready are both high;
// the core holds in_ready (resp. out_valid/out_data) until that cycle and
// drops it on the next one. in_ready and out_valid are never high together.
module cpu_core_p import cpu_pkg::*; #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6,
  parameter int PC_RESET   = 8,
  parameter logic [ADDR_WIDTH-1:0] SP_RESET = '1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] sp,
  output logic                  halted,
  output logic                  error
);

  localparam int DW = DATA_WIDTH;
  localparam int AW = ADDR_WIDTH;

  state_t        state;
  opi_t          opi;
  logic          ind;      // second read of an indirect operand pending
  logic [DW-1:0] opa, opb, res, alu_y;
  logic [AW-1:0] target;
  logic [15:0]   ir;
  logic [AW-1:0] mar, mar_d, rd_addr;
  logic [DW-1:0] mdr, mdr_d;
  logic          mar_en, mdr_en, cur_ind;
  logic [2:0]    cur_field;

  logic [3:0] oc;
  logic       ix, iy, iz;
  logic [2:0] x_f, y_f, z_f;

  assign oc  = ir[F_OC_HI:F_OC_LO];
  assign ix  = ir[F_IX];
  assign x_f = ir[F_X_HI:F_X_LO];
  assign iy  = ir[F_IY];
  assign y_f = ir[F_Y_HI:F_Y_LO];
  assign iz  = ir[F_IZ];
  assign z_f = ir[F_Z_HI:F_Z_LO];

  // Field and addressing mode of the operand currently being read. The
  // destination-pointer read is always a single direct read of mem[x].
  always_comb begin
    cur_ind   = 1'b0;
    cur_field = x_f;
    case (opi)
      OPI_Y:   begin cur_ind = iy;   cur_field = y_f; end
      OPI_Z:   begin cur_ind = iz;   cur_field = z_f; end
      OPI_DST: begin cur_ind = 1'b0; cur_field = x_f; end
      OPI_X:   begin cur_ind = ix;   cur_field = x_f; end
      default: begin cur_ind = 1'b0; cur_field = x_f; end
    endcase
  end

  assign rd_addr = ind ? mdr[AW-1:0] : {{(AW-3){1'b0}}, cur_field};

  always_comb begin
    mar_en = (state == S_FETCH_A) || (state == S_RD_A) || (state == S_WB_A);
    mar_d  = target;
    if (state == S_FETCH_A) mar_d = pc;
    else if (state == S_RD_A) mar_d = rd_addr;
    mdr_en = (state == S_FETCH_L) || (state == S_RD_L) || (state == S_WB_A);
    mdr_d  = (state == S_WB_A) ? res : mem_rdata;
  end

  register #(.W(AW), .RST(AW'(PC_RESET))) u_pc (
    .clk(clk), .rst_n(rst_n), .en(state == S_FETCH_L), .d(pc + AW'(1)), .q(pc));
  register #(.W(AW), .RST(SP_RESET)) u_sp (
    .clk(clk), .rst_n(rst_n), .en(1'b0), .d(sp), .q(sp));
  register #(.W(16)) u_ir (
    .clk(clk), .rst_n(rst_n), .en(state == S_FETCH_L), .d(mem_rdata[15:0]), .q(ir));
  register #(.W(AW)) u_mar (
    .clk(clk), .rst_n(rst_n), .en(mar_en), .d(mar_d), .q(mar));
  register #(.W(DW)) u_mdr (
    .clk(clk), .rst_n(rst_n), .en(mdr_en), .d(mdr_d), .q(mdr));

  assign mem_addr  = mar;
  assign mem_wdata = mdr;

  cpu_alu_p #(.DW(DW)) u_alu (.op(oc), .a(opa), .b(opb), .y(alu_y));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_FETCH_A;
      opi       <= OPI_Y;
      ind       <= 1'b0;
      opa       <= '0;
      opb       <= '0;
      res       <= '0;
      target    <= '0;
      mem_we    <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      halted    <= 1'b0;
      error     <= 1'b0;
    end else begin
      case (state)
        S_FETCH_A: state <= S_FETCH_W;
        S_FETCH_W: state <= S_FETCH_L;
        S_FETCH_L: state <= S_DECODE;
        S_DECODE: begin
          target <= {{(AW-3){1'b0}}, x_f};
          opi    <= OPI_Y;
          ind    <= 1'b0;
          if ((oc == OC_MOV) || is_binop(oc)) begin
            state <= S_RD_A;
          end else if (oc == OC_IN) begin
            in_ready <= 1'b1;
            state    <= S_IN_WAIT;
          end else if (oc == OC_OUT) begin
            opi   <= OPI_X;
            state <= S_RD_A;
          end else if (oc == OC_STOP) begin
            halted <= 1'b1;
            state  <= S_HALT;
          end else begin
            halted <= 1'b1;
            error  <= 1'b1;
            state  <= S_ERROR;
          end
        end
        S_RD_A: state <= S_RD_W;
        S_RD_W: state <= S_RD_L;
        S_RD_L: begin
          if (cur_ind && !ind) begin
            // Pointer word is landing in MDR; re-run the read through it.
            ind   <= 1'b1;
            state <= S_RD_A;
          end else begin
            ind <= 1'b0;
            case (opi)
              OPI_Y: begin
                opa <= mem_rdata;
                if (is_binop(oc)) begin
                  opi   <= OPI_Z;
                  state <= S_RD_A;
                end else if (ix) begin
                  opi   <= OPI_DST;
                  state <= S_RD_A;
                end else begin
                  state <= S_EXEC;
                end
              end
              OPI_Z: begin
                opb <= mem_rdata;
                if (ix) begin
                  opi   <= OPI_DST;
                  state <= S_RD_A;
                end else begin
                  state <= S_EXEC;
                end
              end
              OPI_DST: begin
                target <= mem_rdata[AW-1:0];
                // IN already holds its result; it skips the ALU.
                state  <= (oc == OC_IN) ? S_WB_A : S_EXEC;
              end
              default: begin
                out_data  <= mem_rdata;
                out_valid <= 1'b1;
                state     <= S_OUT_WAIT;
              end
            endcase
          end
        end
        S_EXEC: begin
          res   <= alu_y;
          state <= S_WB_A;
        end
        S_WB_A: begin
          mem_we <= 1'b1;
          state  <= S_WB_W;
        end
        S_WB_W: begin
          mem_we <= 1'b0;
          state  <= S_FETCH_A;
        end
        S_IN_WAIT: begin
          if (in_valid) begin
            res      <= in_data;
            in_ready <= 1'b0;
            if (ix) begin
              opi   <= OPI_DST;
              state <= S_RD_A;
            end else begin
              state <= S_WB_A;
            end
          end
        end
        S_OUT_WAIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_FETCH_A;
          end
        end
        S_HALT:  state <= S_HALT;
        S_ERROR: state <= S_ERROR;
        default: begin
          halted <= 1'b1;
          error  <= 1'b1;
          state  <= S_ERROR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_core_p.sv
// tb_cpu_core_p: directed bench for cpu_core_p. One 16/6 instance runs the
// directed programs; a 32/8 instance runs the basic ADD program alongside.
module tb_cpu_core_p;

  logic clk;
  logic rst_n;

  // 16-bit / 6-bit instance
  logic [15:0] m0_rdata, m0_wdata, in_data, m0_out_data;
  logic [5:0]  m0_addr, m0_pc, m0_sp;
  logic        m0_we, in_valid, m0_in_ready, m0_out_valid, out_ready;
  logic        m0_halted, m0_error;
  logic [15:0] mem0 [64];

  // 32-bit / 8-bit instance
  logic [31:0] m1_rdata, m1_wdata, m1_out_data;
  logic [7:0]  m1_addr, m1_pc, m1_sp;
  logic        m1_we, m1_in_ready, m1_out_valid, m1_halted, m1_error;
  logic [31:0] mem1 [256];

  int checks = 0;
  int failures = 0;
  int we_cnt = 0;
  int we_snap;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cpu_core_p u0 (
    .clk(clk), .rst_n(rst_n), .mem_rdata(m0_rdata), .mem_addr(m0_addr),
    .mem_wdata(m0_wdata), .mem_we(m0_we), .in_data(in_data), .in_valid(in_valid),
    .in_ready(m0_in_ready), .out_data(m0_out_data), .out_valid(m0_out_valid),
    .out_ready(out_ready), .pc(m0_pc), .sp(m0_sp), .halted(m0_halted), .error(m0_error));

  cpu_core_p #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) u1 (
    .clk(clk), .rst_n(rst_n), .mem_rdata(m1_rdata), .mem_addr(m1_addr),
    .mem_wdata(m1_wdata), .mem_we(m1_we), .in_data(32'h0), .in_valid(1'b0),
    .in_ready(m1_in_ready), .out_data(m1_out_data), .out_valid(m1_out_valid),
    .out_ready(1'b0), .pc(m1_pc), .sp(m1_sp), .halted(m1_halted), .error(m1_error));

  // Synchronous RAM models: read data appears the cycle after the address.
  always @(posedge clk) begin
    if (m0_we) begin
      mem0[m0_addr] = m0_wdata;
      we_cnt = we_cnt + 1;
    end
    m0_rdata <= mem0[m0_addr];
  end

  always @(posedge clk) begin
    if (m1_we) mem1[m1_addr] = m1_wdata;
    m1_rdata <= mem1[m1_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic hold_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 64; i++) mem0[i] = 16'h0;
    cyc(2);
  endtask

  task automatic wait_halt(input int bound, input string tag);
    for (int i = 0; i < bound && !m0_halted; i++) cyc(1);
    check(tag, {31'b0, m0_halted}, 32'h1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 16'h0; out_ready = 1'b0;
    for (int i = 0; i < 256; i++) mem1[i] = 32'h0;
    mem1[1] = 32'h0001_0003;
    mem1[2] = 32'h0000_0004;
    mem1[8] = 32'hDEAD_1012;   // ADD x0,y1,z2 with junk in the upper half
    mem1[9] = 32'hFFFF_F000;   // STOP
    cyc(1);

    // ---- reset state + test 1: ADD direct, 13-cycle latency ----
    hold_reset();
    check("rst_pc", m0_pc, 32'd8);
    check("rst_sp", m0_sp, 32'd63);
    check("rst_halted", m0_halted, 0);
    check("rst_error", m0_error, 0);
    check("rst_we", m0_we, 0);
    check("rst_in_ready", m0_in_ready, 0);
    check("rst_out_valid", m0_out_valid, 0);
    check("rst_out_data", m0_out_data, 0);
    check("rst_mem_addr", m0_addr, 0);
    check("rst_u1_sp", m1_sp, 32'd255);
    check("rst_u1_io", {m1_in_ready, m1_out_valid}, 0);
    check("rst_u1_out_data", m1_out_data, 0);
    mem0[1] = 16'd3; mem0[2] = 16'd4;
    mem0[8] = 16'h1012;        // ADD x0,y1,z2
    mem0[9] = 16'hF000;        // STOP
    rst_n = 1'b1;
    cyc(12);
    check("t1_we_cycle13", m0_we, 1);
    check("t1_wb_addr", m0_addr, 0);
    check("t1_wb_data", m0_wdata, 32'd7);
    check("t1_mem0_before", mem0[0], 0);
    check("t1_u1_we", m1_we, 1);
    check("t1_u1_wb_data", m1_wdata, 32'h0001_0007);
    cyc(1);
    check("t1_mem0", mem0[0], 32'd7);
    check("t1_pc", m0_pc, 32'd9);
    check("t1_we_one_cycle", m0_we, 0);
    check("t1_u1_mem0", mem1[0], 32'h0001_0007);
    check("t1_u1_pc", m1_pc, 32'd9);
    wait_halt(50, "t1_halt");
    check("t1_stop_err", m0_error, 0);
    check("t1_stop_pc", m0_pc, 32'd10);
    check("t1_u1_halt", {m1_halted, m1_error}, 32'h2);

    // ---- test 2: MOV indirect y, MUL wrap, SUB with indirect destination ----
    hold_reset();
    mem0[0] = 16'h1111; mem0[1] = 16'hFFC0; mem0[2] = 16'h5555;
    mem0[3] = 16'd5; mem0[5] = 16'h00FF; mem0[6] = 16'h0100; mem0[7] = 16'h0100;
    mem0[8]  = 16'h04B0;       // MOV x4, [y3]
    mem0[9]  = 16'h3267;       // MUL x2, y6, z7
    mem0[10] = 16'h2935;       // SUB [x1], y3, z5
    mem0[11] = 16'hF000;
    rst_n = 1'b1;
    wait_halt(200, "t2_halt");
    check("t2_mov_ind", mem0[4], 32'h00FF);
    check("t2_mul_wrap", mem0[2], 32'h0000);
    check("t2_sub_dst_ind", mem0[0], 32'hFF06);
    check("t2_ptr_kept", mem0[1], 32'hFFC0);
    check("t2_pc", m0_pc, 32'd12);

    // ---- test 3: DIV by zero, DIV, IN with delayed in_valid ----
    hold_reset();
    mem0[3] = 16'd9; mem0[4] = 16'd0; mem0[6] = 16'd100; mem0[7] = 16'd7;
    mem0[8]  = 16'h4534;       // DIV x5, y3, z4  (9/0)
    mem0[9]  = 16'h4267;       // DIV x2, y6, z7  (100/7)
    mem0[10] = 16'h7600;       // IN x6
    mem0[11] = 16'hF000;
    rst_n = 1'b1;
    for (int i = 0; i < 200 && !m0_in_ready; i++) cyc(1);
    check("t3_in_ready_up", m0_in_ready, 1);
    for (int i = 0; i < 5; i++) begin
      check("t3_in_wait", {m0_in_ready, m0_out_valid, m0_we}, 32'h4);
      cyc(1);
    end
    in_valid = 1'b1; in_data = 16'h1234;
    check("t3_handshake", m0_in_ready, 1);
    cyc(1);
    in_valid = 1'b0; in_data = 16'h0;
    check("t3_in_ready_drop", m0_in_ready, 0);
    wait_halt(50, "t3_halt");
    check("t3_div0", mem0[5], 32'hFFFF);
    check("t3_div", mem0[2], 32'h000E);
    check("t3_in_data", mem0[6], 32'h1234);

    // ---- test 4: OUT with stalled consumer, then indirect OUT with early ready ----
    hold_reset();
    check("t4_out_data_rst", m0_out_data, 0);
    mem0[1] = 16'hABCD; mem0[2] = 16'h0003; mem0[3] = 16'h5A5A;
    mem0[8]  = 16'h8100;       // OUT x1
    mem0[9]  = 16'h8A00;       // OUT [x2]
    mem0[10] = 16'hF000;
    rst_n = 1'b1;
    for (int i = 0; i < 100 && !m0_out_valid; i++) cyc(1);
    check("t4_out_valid_up", m0_out_valid, 1);
    check("t4_out_data", m0_out_data, 32'hABCD);
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      check("t4_out_hold", {m0_out_valid, m0_in_ready, m0_out_data}, 32'h2ABCD);
    end
    out_ready = 1'b1;
    check("t4_accept_cycle", m0_out_valid, 1);
    cyc(1);
    check("t4_out_valid_drop", m0_out_valid, 0);
    check("t4_out_data_kept", m0_out_data, 32'hABCD);
    for (int i = 0; i < 100 && !m0_out_valid; i++) cyc(1);
    check("t4_ind_out_data", {m0_out_valid, m0_out_data}, 32'h15A5A);
    cyc(1);
    check("t4_early_ready_1cyc", m0_out_valid, 0);
    out_ready = 1'b0;
    wait_halt(50, "t4_halt");
    check("t4_pc", m0_pc, 32'd11);

    // ---- test 5: illegal opcode, STOP, reset during writeback ----
    hold_reset();
    mem0[8] = 16'h5000;
    we_snap = we_cnt;
    rst_n = 1'b1;
    wait_halt(50, "t5_err_halt");
    check("t5_error", m0_error, 1);
    check("t5_err_pc", m0_pc, 32'd9);
    cyc(5);
    check("t5_error_sticky", {m0_halted, m0_error, m0_we}, 32'h6);
    check("t5_no_write", we_cnt, we_snap);

    hold_reset();
    mem0[8] = 16'hF000;
    rst_n = 1'b1;
    wait_halt(50, "t5_stop_halt");
    check("t5_stop_error", m0_error, 0);
    check("t5_stop_pc", m0_pc, 32'd9);

    hold_reset();
    mem0[1] = 16'd3; mem0[2] = 16'd4; mem0[8] = 16'h1012;
    rst_n = 1'b1;
    cyc(12);
    check("t5_in_ww", m0_we, 1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_we", m0_we, 0);
    check("t5_rst_pc", m0_pc, 32'd8);
    cyc(1);
    check("t5_write_dropped", mem0[0], 0);

    // ---- test 6: PC wrap from 63 to 0 ----
    hold_reset();
    for (int i = 8; i < 63; i++) mem0[i] = 16'h0770;   // MOV x7, y7 filler
    mem0[63] = 16'h1412;       // ADD x4, y1, z2
    mem0[0]  = 16'hF000;
    mem0[1]  = 16'd3; mem0[2] = 16'd4;
    rst_n = 1'b1;
    for (int i = 0; i < 1000 && (m0_pc != 6'd0); i++) cyc(1);
    check("t6_pc_wrap", m0_pc, 0);
    check("t6_add_pending", mem0[4], 0);
    wait_halt(100, "t6_halt");
    check("t6_add_result", mem0[4], 32'd7);
    check("t6_pc_after_stop", {m0_error, m0_pc}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
